// File: rtl/instr_fetch_if.sv
// Fetch-unit signal bundle: ROM read port, execute-stage redirect, decoder valid/ready handshake.
// The master modport is the fetch unit. The slave modport is the ROM/execute/decoder environment.
interface instr_fetch_if;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic        misalign_err;

    modport master (
        output mem_req, mem_addr, instr_valid, instr_data, instr_pc, misalign_err,
        input  mem_rdata, redirect_valid, redirect_pc, instr_ready
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data, instr_pc, misalign_err,
        output mem_rdata, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC, one-cycle-latency ROM port, DEPTH-entry prefetch FIFO.
// Optional IFETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and raise misalign_err.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input logic           clk,
    input logic           rst,
    instr_fetch_if.master bus
);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW:0] DepthOcc = (CntW + 1)'(DEPTH);

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     data_mem [DEPTH];

    logic            halted;
    logic [31:0]     redirect_target;
    logic [CntW:0]   occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    logic            head_valid;

`ifdef IFETCH_ALIGN_CHECK_EN
    logic halted_q, halted_d;
    logic misalign_q, misalign_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            halted_q   <= halted_d;
            misalign_q <= misalign_d;
        end
    end

    // Every redirect re-evaluates alignment; an aligned target clears the halt.
    always_comb begin
        halted_d   = halted_q;
        misalign_d = misalign_q;
        if (bus.redirect_valid) begin
            halted_d   = (bus.redirect_pc[1:0] != 2'b00);
            misalign_d = (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    assign halted           = halted_q;
    assign bus.misalign_err = misalign_q;
    assign redirect_target  = bus.redirect_pc;
`else
    logic unused_align;
    assign unused_align     = ^bus.redirect_pc[1:0];
    assign halted           = 1'b0;
    assign bus.misalign_err = 1'b0;
    assign redirect_target  = {bus.redirect_pc[31:2], 2'b00};
`endif

    // Count the in-flight read so a late response always finds a free slot.
    assign occupancy  = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign issue      = !rst && !bus.redirect_valid && !halted && (occupancy < DepthOcc);
    assign push       = inflight_q && !bus.redirect_valid;
    assign head_valid = (count_q != '0);
    assign pop        = head_valid && bus.instr_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = redirect_target;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d    = fetch_pc_q + 32'd4;
                inflight_d    = 1'b1;
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[wr_ptr_q]   <= inflight_pc_q;
            data_mem[wr_ptr_q] <= bus.mem_rdata;
        end
    end

    assign bus.mem_req     = issue;
    assign bus.mem_addr    = fetch_pc_q;
    assign bus.instr_valid = head_valid;
    assign bus.instr_data  = head_valid ? data_mem[rd_ptr_q] : 32'h0;
    assign bus.instr_pc    = head_valid ? pc_mem[rd_ptr_q] : 32'h0;
endmodule
